// File: rtl/dmem_latency_responder.sv
// MEM-stage data-memory responder: services loads/stores from an internal word array
// after a fixed latency, pulses ready for one cycle and stalls the pipeline meanwhile.
module dmem_latency_responder #(
  parameter int WORD_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [WORD_W-1:0] i_mem_address,
  input  logic [WORD_W-1:0] i_mem_wdata,
  output logic [WORD_W-1:0] o_mem_rdata,
  output logic              o_mem_ready,
  output logic              o_mem_stall,
  output logic              o_mem_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = (LATENCY > 2) ? CW'(LATENCY - 2) : '0;
  localparam logic [WORD_W-1:0] DEPTH_W = WORD_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [WORD_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic              r_is_write;
  logic              r_conflict;
  logic [WORD_W-1:0] r_rdata;
  logic              r_ready;
  logic              r_err;
  logic [WORD_W-1:0] r_mem [DEPTH];

  logic              w_req;
  logic              w_in_idle;
  logic              w_access;
  logic [WORD_W-1:0] w_addr;
  logic [WORD_W-1:0] w_wdata;
  logic              w_is_write;
  logic              w_conflict;
  logic [WORD_W-1:0] w_word_addr;
  logic              w_misaligned;
  logic              w_oob;
  logic              w_bad;
  logic              w_err;
  logic [AW-1:0]     w_idx;

  assign w_req     = i_mem_read | i_mem_write;
  assign w_in_idle = (r_state == IDLE);

  // With LATENCY==1 the access happens on the accept edge, so it must use the live inputs.
  assign w_addr     = w_in_idle ? i_mem_address : r_addr;
  assign w_wdata    = w_in_idle ? i_mem_wdata   : r_wdata;
  assign w_is_write = w_in_idle ? i_mem_write   : r_is_write;
  assign w_conflict = w_in_idle ? (i_mem_read & i_mem_write) : r_conflict;

  assign w_access = i_rst_n &&
                    ((w_in_idle && w_req && (LATENCY == 1)) ||
                     ((r_state == BUSY) && (r_cnt == '0)));

  assign w_word_addr  = {2'b00, w_addr[WORD_W-1:2]};
  assign w_misaligned = |w_addr[1:0];
  assign w_oob        = (w_word_addr >= DEPTH_W);
  assign w_bad        = w_misaligned | w_oob;
  assign w_err        = w_bad | w_conflict;
  assign w_idx        = w_addr[2 +: AW];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_is_write <= 1'b0;
      r_conflict <= 1'b0;
      r_rdata    <= '0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr     <= i_mem_address;
            r_wdata    <= i_mem_wdata;
            r_is_write <= i_mem_write;
            r_conflict <= i_mem_read & i_mem_write;
            if (LATENCY == 1) begin
              r_state <= RESP;
            end else begin
              r_state <= BUSY;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_state <= RESP;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      // Faulty reads return zero; writes leave the load-data register untouched.
      if (w_access) begin
        r_ready <= 1'b1;
        r_err   <= w_err;
        if (!w_is_write) begin
          r_rdata <= w_bad ? '0 : r_mem[w_idx];
        end
      end
    end
  end

  // The array is never reset; w_access is gated by reset so an aborted write never lands.
  always_ff @(posedge i_clk) begin
    if (w_access && w_is_write && !w_bad) begin
      r_mem[w_idx] <= w_wdata;
    end
  end

  assign o_mem_rdata = r_rdata;
  assign o_mem_ready = r_ready;
  assign o_mem_err   = r_err;
  assign o_mem_stall = (w_in_idle & w_req) | (r_state == BUSY);

endmodule

// File: tb/tb_dmem_latency_responder.sv
// Directed bench for dmem_latency_responder: a LATENCY=4 instance driven from a vector
// table plus corner sequences, and a LATENCY=1 instance for the single-cycle path.
module tb_dmem_latency_responder;

  localparam int LAT = 4;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expErr;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        rd, wr;
  logic [31:0] addr, wdata, rdata;
  logic        ready, stall, err;
  logic        rd1, wr1;
  logic [31:0] addr1, wdata1, rdata1;
  logic        ready1, stall1, err1;

  int nChecks;
  int nFails;

  vec_t        vecs [15];
  int          bbCyc  [3];
  logic [31:0] bbAddr [3];
  logic [31:0] bbData [3];

  dmem_latency_responder #(.WORD_W(32), .DEPTH(256), .LATENCY(LAT)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_mem_read(rd), .i_mem_write(wr), .i_mem_address(addr), .i_mem_wdata(wdata),
    .o_mem_rdata(rdata), .o_mem_ready(ready), .o_mem_stall(stall), .o_mem_err(err)
  );

  dmem_latency_responder #(.WORD_W(32), .DEPTH(256), .LATENCY(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_mem_read(rd1), .i_mem_write(wr1), .i_mem_address(addr1), .i_mem_wdata(wdata1),
    .o_mem_rdata(rdata1), .o_mem_ready(ready1), .o_mem_stall(stall1), .o_mem_err(err1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // One full transaction on the LATENCY=4 instance, request held until ready.
  task automatic applyStimulus(input vec_t v, input string tag);
    int cyc;
    bit seen;
    @(negedge clk);
    rd = v.rd; wr = v.wr; addr = v.addr; wdata = v.wdata;
    #1;
    checkOutput({tag, " stall@req"}, {31'b0, stall}, 32'd1);
    checkOutput({tag, " ready@req"}, {31'b0, ready}, 32'd0);
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk); #1;
      cyc++;
      if (ready) seen = 1;
      else checkOutput({tag, " stall busy"}, {31'b0, stall}, 32'd1);
    end
    if (!seen) begin
      checkOutput({tag, " ready timeout"}, 32'd0, 32'd1);
    end else begin
      checkOutput({tag, " latency"}, cyc, LAT);
      checkOutput({tag, " rdata"}, rdata, v.expRdata);
      checkOutput({tag, " err"}, {31'b0, err}, {31'b0, v.expErr});
      checkOutput({tag, " stall@resp"}, {31'b0, stall}, 32'd0);
    end
    rd = 0; wr = 0;
  endtask

  // One access on the LATENCY=1 instance: stall only in the request cycle, ready next.
  task automatic checkLat1(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] expRd,
                           input logic expE, input string tag);
    @(negedge clk);
    rd1 = r; wr1 = w; addr1 = a; wdata1 = d;
    #1;
    checkOutput({tag, " stall@req"}, {31'b0, stall1}, 32'd1);
    checkOutput({tag, " ready@req"}, {31'b0, ready1}, 32'd0);
    @(negedge clk); #1;
    checkOutput({tag, " ready"}, {31'b0, ready1}, 32'd1);
    checkOutput({tag, " stall@resp"}, {31'b0, stall1}, 32'd0);
    checkOutput({tag, " rdata"}, rdata1, expRd);
    checkOutput({tag, " err"}, {31'b0, err1}, {31'b0, expE});
    rd1 = 0; wr1 = 0;
    @(negedge clk); #1;
    checkOutput({tag, " ready after"}, {31'b0, ready1}, 32'd0);
    checkOutput({tag, " stall after"}, {31'b0, stall1}, 32'd0);
  endtask

  initial begin
    int cyc;
    int n;
    nChecks = 0;
    nFails  = 0;
    rd = 0; wr = 0; addr = 0; wdata = 0;
    rd1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0;

    // rd, wr, addr, wdata, expected rdata, expected err
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0400, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0011, 32'h1234_5678, 32'h0000_0000, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_0400, 32'h8765_4321, 32'h0000_0000, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h5A5A_5A5A, 32'hCAFE_F00D, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'h5A5A_5A5A, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_0030, 32'h1111_2222, 32'h5A5A_5A5A, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 32'h0000_03FC, 32'hFFFF_0001, 32'h5A5A_5A5A, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0000_0000, 32'hFFFF_0001, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 32'h0000_0030, 32'h0000_0000, 32'h1111_2222, 1'b0};

    bbCyc[0]  = 4;             bbCyc[1]  = 9;             bbCyc[2]  = 14;
    bbAddr[0] = 32'h10;        bbAddr[1] = 32'h00;        bbAddr[2] = 32'h20;
    bbData[0] = 32'hDEAD_BEEF; bbData[1] = 32'hCAFE_F00D; bbData[2] = 32'h5A5A_5A5A;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    checkOutput("reset rdata", rdata, 32'h0);
    checkOutput("reset ready", {31'b0, ready}, 32'd0);
    checkOutput("reset err", {31'b0, err}, 32'd0);
    checkOutput("reset stall", {31'b0, stall}, 32'd0);
    checkOutput("reset ready1", {31'b0, ready1}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    checkLat1(1'b0, 1'b1, 32'h0, 32'hA5A5_A5A5, 32'h0, 1'b0, "lat1 write");
    checkLat1(1'b1, 1'b0, 32'h0, 32'h0, 32'hA5A5_A5A5, 1'b0, "lat1 read");
    checkLat1(1'b1, 1'b0, 32'h2, 32'h0, 32'h0, 1'b1, "lat1 misaligned");

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Request dropped after acceptance must still complete.
    @(negedge clk);
    rd = 1; addr = 32'h10;
    @(negedge clk);
    rd = 0; addr = 32'h0;
    cyc = 1;
    #1;
    while (!ready && cyc < 20) begin
      @(negedge clk); #1;
      cyc++;
    end
    checkOutput("dropped latency", cyc, LAT);
    checkOutput("dropped rdata", rdata, 32'hDEAD_BEEF);

    // Back-to-back reads with the request held through each RESP cycle.
    @(negedge clk);
    rd = 1; addr = bbAddr[0];
    n = 0;
    cyc = 0;
    while (n < 3 && cyc < 30) begin
      @(negedge clk); #1;
      cyc++;
      if (ready) begin
        checkOutput($sformatf("b2b%0d cycle", n), cyc, bbCyc[n]);
        checkOutput($sformatf("b2b%0d rdata", n), rdata, bbData[n]);
        n++;
        if (n < 3) addr = bbAddr[n];
        else rd = 0;
      end else begin
        checkOutput($sformatf("b2b stall c%0d", cyc), {31'b0, stall}, 32'd1);
      end
    end
    checkOutput("b2b pulses", n, 3);
    rd = 0;

    // Abort a write to 0x30 with reset while BUSY cnt=1; old contents must survive.
    @(negedge clk);
    wr = 1; addr = 32'h30; wdata = 32'h3333_4444;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort rdata", rdata, 32'h0);
    checkOutput("abort ready", {31'b0, ready}, 32'd0);
    checkOutput("abort err", {31'b0, err}, 32'd0);
    wr = 0; addr = 0; wdata = 0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus('{1'b1, 1'b0, 32'h30, 32'h0, 32'h1111_2222, 1'b0}, "after abort");

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
